// File: rtl/loader_wb_pkg.sv
// Shared types for the loader/core wishbone arbiter:
// arbiter states, loader FIFO entry layout and address helpers.
package loader_wb_pkg;

   localparam int IO_AW  = 25;
   localparam int RAM_BW = 26;
   localparam int WADR_W = RAM_BW - 2;

   typedef enum logic [1:0] {
      S_CORE,
      S_GRANT,
      S_LOAD,
      S_DRAIN
   } arb_state_e;

   typedef struct packed {
      logic [WADR_W-1:0] wadr;
      logic [3:0]        sel;
      logic [31:0]       dat;
   } fifo_entry_t;

   // Keeps byte-address bits [aw-1:2]; lane bits and bits above aw are cleared
   function automatic logic [RAM_BW-1:0] adr_mask(input int aw);
      logic [RAM_BW-1:0] m;
      for (int i = 0; i < RAM_BW; i++) begin
         m[i] = (i >= 2) && (i < aw);
      end
      return m;
   endfunction

endpackage

// File: rtl/loader_wb_fifo.sv
// Small synchronous FIFO holding loader write words.
// Head entry is read straight from storage (no output register).
module loader_wb_fifo
   import loader_wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fifo_entry_t              din,
   input  logic                     pop,
   output fifo_entry_t              dout,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   fifo_entry_t   mem_q [DEPTH];
   logic [PW-1:0] wr_q, wr_d;
   logic [PW-1:0] rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          do_push;
   logic          do_pop;

   assign full    = (cnt_q == CW'(DEPTH));
   assign empty   = (cnt_q == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign dout    = mem_q[rd_q];
   assign count   = cnt_q;

   // Pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_d  = wr_q + PW'(do_push);
      rd_d  = rd_q + PW'(do_pop);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_q] <= din;
      end
   end

endmodule

// File: rtl/loader_wb_arbiter.sv
// Arbitrates the SDRAM wishbone port between the core and the ioctl
// loader; buffers download words and holds the core while they drain.
module loader_wb_arbiter
   import loader_wb_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int RAM_AW     = 24
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ioctl_download,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [31:0] ioctl_dout,
   input  logic [3:0]  ioctl_sel,
   output logic        ioctl_wait,
   input  logic        core_stb,
   input  logic        core_cyc,
   input  logic        core_we,
   input  logic [3:0]  core_sel,
   input  logic [24:0] core_adr,
   input  logic [31:0] core_dat,
   output logic        core_ack,
   output logic        core_hold,
   output logic        ram_stb,
   output logic        ram_cyc,
   output logic        ram_we,
   output logic [3:0]  ram_sel,
   output logic [25:0] ram_adr,
   output logic [31:0] ram_dat,
   input  logic        ram_ack,
   output logic        load_done,
   output logic        overflow
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [RAM_BW-1:0] ADR_MASK = adr_mask(RAM_AW);

   arb_state_e        state_q, state_d;
   logic              dl_q;
   logic              stb_q, stb_d;
   logic [WADR_W-1:0] adr_q, adr_d;
   logic [3:0]        sel_q, sel_d;
   logic [31:0]       dat_q, dat_d;
   logic              wait_q, wait_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              ovf_q, ovf_d;

   logic              push;
   logic              pop;
   logic              dl_rise;
   logic              pass;
   logic              loading;
   logic [RAM_BW-1:0] ld_adr;
   fifo_entry_t       in_ent;
   fifo_entry_t       head;
   logic [CW-1:0]     count;
   logic [CW-1:0]     cnt_nxt;
   logic              full;
   logic              empty;
   logic              unused;

   assign ld_adr  = {1'b0, ioctl_addr} & ADR_MASK;
   assign in_ent  = '{wadr: ld_adr[RAM_BW-1:2], sel: ioctl_sel, dat: ioctl_dout};
   assign push    = ioctl_wr & ~full;
   assign pop     = stb_q & ram_ack;
   assign dl_rise = ioctl_download & ~dl_q;
   assign pass    = (state_q == S_CORE) || (state_q == S_GRANT);
   assign loading = (state_q == S_LOAD) || (state_q == S_DRAIN);
   assign unused  = ^{core_cyc, core_adr[24], ld_adr[1:0]};

   loader_wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk_sys),
      .reset (reset),
      .push  (push),
      .din   (in_ent),
      .pop   (pop),
      .dout  (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   always_comb begin
      state_d = state_q;
      stb_d   = stb_q;
      adr_d   = adr_q;
      sel_d   = sel_q;
      dat_d   = dat_q;
      done_d  = 1'b0;
      ovf_d   = ovf_q | (ioctl_wr & full);
      cnt_nxt = count + CW'(push) - CW'(pop);
      wait_d  = (cnt_nxt >= CW'(FIFO_DEPTH - 1));

      unique case (state_q)
         S_CORE: begin
            if (dl_rise) begin
               state_d = (core_stb & ~ram_ack) ? S_GRANT : S_LOAD;
            end
         end
         S_GRANT: begin
            if (ram_ack | ~core_stb) begin
               state_d = S_LOAD;
            end
         end
         S_LOAD: begin
            if (!ioctl_download) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (ioctl_download) begin
               state_d = S_LOAD;
            end else if (empty & ~stb_q & ~push) begin
               state_d = S_CORE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_CORE;
      endcase

      // Idle stb cycle after each ack separates consecutive words
      if (stb_q) begin
         if (ram_ack) begin
            stb_d = 1'b0;
         end
      end else if (loading && !empty) begin
         stb_d = 1'b1;
         adr_d = head.wadr;
         sel_d = head.sel;
         dat_d = head.dat;
      end

      hold_d = (state_d != S_CORE);
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q <= S_CORE;
         dl_q    <= 1'b0;
         stb_q   <= 1'b0;
         adr_q   <= '0;
         sel_q   <= '0;
         dat_q   <= '0;
         wait_q  <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         dl_q    <= ioctl_download;
         stb_q   <= stb_d;
         adr_q   <= adr_d;
         sel_q   <= sel_d;
         dat_q   <= dat_d;
         wait_q  <= wait_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         ovf_q   <= ovf_d;
      end
   end

   always_comb begin
      if (pass) begin
         ram_stb = core_stb;
         ram_cyc = core_stb;
         ram_we  = core_we;
         ram_sel = core_sel;
         ram_adr = {core_adr[23:0], 2'b00};
         ram_dat = core_dat;
      end else begin
         ram_stb = stb_q;
         ram_cyc = stb_q;
         ram_we  = stb_q;
         ram_sel = sel_q;
         ram_adr = {adr_q, 2'b00};
         ram_dat = dat_q;
      end
   end

   assign core_ack   = pass & ram_ack;
   assign ioctl_wait = wait_q;
   assign core_hold  = hold_q;
   assign load_done  = done_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_loader_wb_arbiter.sv
// Self-checking bench for loader_wb_arbiter: vector table, corner
// sequences and randomized downloads against an in-order word model.
module tb_loader_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [31:0] ioctl_dout;
   logic [3:0]  ioctl_sel;
   logic        ioctl_wait;
   logic        core_stb, core_cyc, core_we;
   logic [3:0]  core_sel;
   logic [24:0] core_adr;
   logic [31:0] core_dat;
   logic        core_ack;
   logic        core_hold;
   logic        ram_stb, ram_cyc, ram_we;
   logic [3:0]  ram_sel;
   logic [25:0] ram_adr;
   logic [31:0] ram_dat;
   logic        ram_ack = 1'b0;
   logic        load_done;
   logic        overflow;

   typedef struct {
      logic [25:0] adr;
      logic [3:0]  sel;
      logic [31:0] dat;
   } wb_t;

   typedef struct {
      logic [24:0] addr;
      logic [31:0] dat;
      logic [3:0]  sel;
      logic [25:0] exp_adr;
   } vec_t;

   wb_t  log_q [$];
   wb_t  exp_q [$];
   vec_t vt [5];
   int   pass_cnt = 0;
   int   total = 0;
   int   ack_lat = 1;
   int   wcnt = 0;
   int   core_ack_cnt = 0;
   int   leak_cnt = 0;

   always #5 clk = ~clk;

   loader_wb_arbiter dut (
      .clk_sys        (clk),
      .reset          (reset),
      .ioctl_download (ioctl_download),
      .ioctl_wr       (ioctl_wr),
      .ioctl_addr     (ioctl_addr),
      .ioctl_dout     (ioctl_dout),
      .ioctl_sel      (ioctl_sel),
      .ioctl_wait     (ioctl_wait),
      .core_stb       (core_stb),
      .core_cyc       (core_cyc),
      .core_we        (core_we),
      .core_sel       (core_sel),
      .core_adr       (core_adr),
      .core_dat       (core_dat),
      .core_ack       (core_ack),
      .core_hold      (core_hold),
      .ram_stb        (ram_stb),
      .ram_cyc        (ram_cyc),
      .ram_we         (ram_we),
      .ram_sel        (ram_sel),
      .ram_adr        (ram_adr),
      .ram_dat        (ram_dat),
      .ram_ack        (ram_ack),
      .load_done      (load_done),
      .overflow       (overflow)
   );

   // SDRAM slave: ack after ack_lat idle cycles, log writes as accepted
   always @(negedge clk) begin
      if (ram_ack) begin
         ram_ack = 1'b0;
         wcnt = 0;
      end else if (ram_stb && ram_cyc && !reset) begin
         if (wcnt >= ack_lat) begin
            ram_ack = 1'b1;
            if (ram_we) log_q.push_back('{ram_adr, ram_sel, ram_dat});
         end else begin
            wcnt++;
         end
      end else begin
         wcnt = 0;
      end
   end

   always @(negedge clk) begin
      #2;
      if (core_ack) core_ack_cnt++;
      if (core_ack && ram_we) leak_cnt++;
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      total++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   task automatic timeout(input string nm);
      total++;
      $display("FAIL %s: timed out waiting for DUT", nm);
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic ld_write(input logic [24:0] a, input logic [31:0] d,
                           input logic [3:0] s);
      ioctl_wr   = 1'b1;
      ioctl_addr = a;
      ioctl_dout = d;
      ioctl_sel  = s;
      cyc();
      ioctl_wr   = 1'b0;
   endtask

   task automatic wait_ready(input string nm);
      int n = 0;
      while (ioctl_wait && n < 300) begin
         cyc();
         n++;
      end
      if (n >= 300) timeout(nm);
   endtask

   task automatic finish_dl(input string nm);
      int n = 0;
      ioctl_download = 1'b0;
      while (!load_done && n < 400) begin
         cyc();
         n++;
      end
      if (n >= 400) begin
         timeout(nm);
      end else begin
         chk({nm, ".hold_at_done"}, 64'(core_hold), 64'd0);
         cyc();
         chk({nm, ".done_pulse"}, 64'(load_done), 64'd0);
      end
   endtask

   task automatic check_log(input string nm, input logic [25:0] a,
                            input logic [3:0] s, input logic [31:0] d);
      wb_t e;
      if (log_q.size() == 0) begin
         total++;
         $display("FAIL %s: no ram write seen, expected adr %h", nm, a);
      end else begin
         e = log_q.pop_front();
         chk({nm, ".adr"}, 64'(e.adr), 64'(a));
         chk({nm, ".sel"}, 64'(e.sel), 64'(s));
         chk({nm, ".dat"}, 64'(e.dat), 64'(d));
      end
   endtask

   initial begin
      logic [24:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      int          n;
      int          nst;

      vt[0] = '{25'h0000104, 32'hDEADBEEF, 4'hF, 26'h0000104};
      vt[1] = '{25'h1FFFFFC, 32'h12345678, 4'h3, 26'h0FFFFFC};
      vt[2] = '{25'h1000000, 32'hCAFEF00D, 4'h1, 26'h0000000};
      vt[3] = '{25'h0ABCDE8, 32'h0F0F0F0F, 4'hC, 26'h0ABCDE8};
      vt[4] = '{25'h0FFFFFF, 32'hA5A55A5A, 4'h8, 26'h0FFFFFC};

      ioctl_download = 0; ioctl_wr = 0; ioctl_addr = '0;
      ioctl_dout = '0; ioctl_sel = '0;
      core_stb = 0; core_cyc = 0; core_we = 0; core_sel = '0;
      core_adr = '0; core_dat = '0;
      do_reset();

      chk("rst.wait", 64'(ioctl_wait), 64'd0);
      chk("rst.hold", 64'(core_hold), 64'd0);
      chk("rst.done", 64'(load_done), 64'd0);
      chk("rst.ovf", 64'(overflow), 64'd0);
      chk("rst.stb", 64'({ram_stb, ram_cyc, ram_we}), 64'd0);

      // Single-word downloads: address mapping and 2-cycle latency
      ack_lat = 1;
      for (int i = 0; i < 5; i++) begin
         ioctl_download = 1'b1;
         cyc();
         chk($sformatf("vec%0d.hold", i), 64'(core_hold), 64'd1);
         ld_write(vt[i].addr, vt[i].dat, vt[i].sel);
         chk($sformatf("vec%0d.stb_early", i), 64'(ram_stb), 64'd0);
         cyc();
         chk($sformatf("vec%0d.stb", i),
             64'({ram_stb, ram_cyc, ram_we}), 64'd7);
         chk($sformatf("vec%0d.ram_adr", i), 64'(ram_adr),
             64'(vt[i].exp_adr));
         finish_dl($sformatf("vec%0d", i));
         check_log($sformatf("vec%0d", i), vt[i].exp_adr,
                   vt[i].sel, vt[i].dat);
      end

      // Six words through a slow slave honouring ioctl_wait
      ack_lat = 5;
      ioctl_download = 1'b1;
      cyc();
      for (int i = 0; i < 6; i++) begin
         wait_ready("six.wait");
         ld_write(25'(32'h200 + 4 * i), 32'h1000 + i, 4'hF);
         if (i == 1) chk("six.wait_after2", 64'(ioctl_wait), 64'd0);
         if (i == 2) chk("six.wait_after3", 64'(ioctl_wait), 64'd1);
      end
      finish_dl("six");
      chk("six.ovf", 64'(overflow), 64'd0);
      for (int i = 0; i < 6; i++) begin
         check_log($sformatf("six%0d", i), 26'(32'h200 + 4 * i),
                   4'hF, 32'h1000 + i);
      end

      // Download rises while a core read awaits its ack
      ack_lat = 3;
      core_ack_cnt = 0;
      core_stb = 1; core_cyc = 1; core_we = 0;
      core_adr = 25'h123; core_sel = 4'hF;
      cyc();
      ioctl_download = 1'b1;
      cyc();
      chk("grant.hold", 64'(core_hold), 64'd1);
      ld_write(25'h000400, 32'hBEEF0001, 4'hF);
      n = 0;
      while (core_ack_cnt == 0 && n < 50) begin
         cyc();
         n++;
      end
      if (n >= 50) timeout("grant.core_ack");
      cyc();
      core_stb = 0; core_cyc = 0;
      finish_dl("grant");
      chk("grant.core_acks", 64'(core_ack_cnt), 64'd1);
      check_log("grant", 26'h0000400, 4'hF, 32'hBEEF0001);

      // Forced write into a full FIFO is dropped and sets overflow
      ack_lat = 30;
      ioctl_download = 1'b1;
      cyc();
      for (int i = 0; i < 5; i++) begin
         ld_write(25'(32'h800 + 4 * i), 32'h5000 + i, 4'hF);
      end
      chk("ovf.set", 64'(overflow), 64'd1);
      finish_dl("ovf");
      for (int i = 0; i < 4; i++) begin
         check_log($sformatf("ovf%0d", i), 26'(32'h800 + 4 * i),
                   4'hF, 32'h5000 + i);
      end
      chk("ovf.dropped", 64'(log_q.size()), 64'd0);
      chk("ovf.sticky", 64'(overflow), 64'd1);
      do_reset();
      chk("ovf.cleared", 64'(overflow), 64'd0);

      // Reset while a loader write is on the bus
      ack_lat = 10;
      ioctl_download = 1'b1;
      cyc();
      ld_write(25'h000900, 32'h77777777, 4'hF);
      ld_write(25'h000904, 32'h88888888, 4'hF);
      chk("rmid.stb_before", 64'(ram_stb), 64'd1);
      reset = 1'b1;
      ioctl_download = 1'b0;
      cyc();
      chk("rmid.stb", 64'(ram_stb), 64'd0);
      chk("rmid.wait", 64'(ioctl_wait), 64'd0);
      chk("rmid.hold", 64'(core_hold), 64'd0);
      reset = 1'b0;
      ioctl_download = 1'b1;
      cyc();
      nst = 0;
      for (int i = 0; i < 20; i++) begin
         if (ram_stb) nst++;
         cyc();
      end
      chk("rmid.no_replay", 64'(nst), 64'd0);
      finish_dl("rmid");
      chk("rmid.log_empty", 64'(log_q.size()), 64'd0);

      // Randomized downloads against an in-order word model
      for (int r = 0; r < 4; r++) begin
         ack_lat = $urandom_range(0, 4);
         ioctl_download = 1'b1;
         cyc();
         n = $urandom_range(5, 15);
         for (int i = 0; i < n; i++) begin
            a = 25'($urandom) & 25'h1FFFFFC;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            exp_q.push_back('{26'(a % (1 << 24)), s, d});
            wait_ready("rnd.wait");
            ld_write(a, d, s);
            repeat ($urandom_range(0, 2)) cyc();
         end
         finish_dl($sformatf("rnd%0d", r));
         chk($sformatf("rnd%0d.count", r), 64'(log_q.size()),
             64'(exp_q.size()));
         while (exp_q.size() > 0) begin
            wb_t e;
            e = exp_q.pop_front();
            check_log($sformatf("rnd%0d", r), e.adr, e.sel, e.dat);
         end
      end
      chk("rnd.ovf", 64'(overflow), 64'd0);
      chk("leak.core_ack", 64'(leak_cnt), 64'd0);

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
